mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It generalises the execute stage's combinational MULT/DIV/MFHI/MFLO handling to WIDTH-bit operands.
- Adds iterative signed/unsigned division, an optional single-cycle multiplier, MTHI/MTLO, cancel on pipeline flush, and a busy/done handshake.
- Sits beside the ALU in execute; decode stalls on busy.

Parameters:
- WIDTH, 32, operand width and width of each of HI/LO.
- FAST_MUL, 0, 1 = MULT/MULTU complete in one cycle; 0 = iterative shift-add over WIDTH cycles.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when busy=0.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
- rs_data  input  WIDTH  multiplicand/dividend, or MTHI/MTLO source.
- rt_data  input  WIDTH  multiplier/divisor.
- cancel  input  1  flush; aborts any in-flight operation.
- busy  output  1  operation in progress; new start is ignored.
- done  output  1  one-cycle pulse; HI/LO updated and valid.
- div_zero  output  1  last accepted DIV/DIVU had rt_data=0; held until next accepted start.
- hi  output  WIDTH  HI register (MFHI source).
- lo  output  WIDTH  LO register (MFLO source).

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0.
- States and transitions:
  - IDLE -> RUN on accepted iterative op.
  - RUN -> FIX when counter reaches WIDTH.
  - FIX -> IDLE.
  - cancel forces IDLE at the next edge from any state.
- Acceptance: at edge E0, start=1, busy=0, valid op, cancel=0. Operands and op are latched; later input changes have no effect.
- Iterative timing (DIV, DIVU; MULT/MULTU when FAST_MUL=0):
  - busy=1 from after E0 through edge E(WIDTH+1).
  - RUN performs one iteration per edge, E1..E(WIDTH); counter counts 0..WIDTH-1.
  - FIX at E(WIDTH+1) applies sign correction and writes hi/lo.
  - After E(WIDTH+1): done=1 for exactly one cycle and busy=0 in that same cycle.
  - A new start is accepted in the done cycle.
- Single-cycle ops (MTHI, MTLO; MULT/MULTU when FAST_MUL=1): hi/lo written at E0; done=1 in the following cycle; busy stays 0.
- MTHI writes hi=rs_data only; MTLO writes lo=rs_data only.
- Multiply:
  - Full 2*WIDTH product: {hi,lo} = rs*rt.
  - MULT is signed two's complement: magnitudes are multiplied, then the result is negated in FIX if the operand signs differ.
  - MULTU is unsigned.
- Divide:
  - Restoring algorithm on magnitudes; lo=quotient, hi=remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divisor zero: lo = all ones, hi = rs_data (as latched), div_zero=1. Still runs the full WIDTH+2 latency.
  - DIV of most-negative value by -1: lo = most-negative value, hi=0, no flag.
- Cancel:
  - Next edge: busy=0, state=IDLE, no done pulse. hi/lo keep their pre-operation values; div_zero is unchanged.
  - cancel and start in the same cycle: the start is ignored.
  - cancel has no effect in IDLE.
- Ignored requests: start while busy=1, or op 110/111, leaves all state unchanged and produces no done.
- hi/lo change only at the FIX edge, at a single-cycle op edge, or on reset.

Test Plan:
- WIDTH=32, FAST_MUL=0, MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done pulses in cycle 34 after the accept edge; busy high cycles 1..33.
- MULT -3 * 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Repeat with FAST_MUL=1 -> same result, done the cycle after accept, busy never high.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=0x00000007, div_zero=1; the next accepted MTLO clears div_zero.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, div_zero=0.
- Start DIVU 100/7 after setting hi=0x1234 via MTHI. Pulse start with MULT at RUN cycle 5 -> ignored. Assert cancel at RUN cycle 10 -> busy=0 next cycle, no done, hi=0x1234 retained.
- Drop reset_n mid-RUN of DIV (asynchronously, between edges) -> busy=0 and hi=lo=0 immediately. After release, DIVU 100/7 -> lo=14, hi=2.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Iterative shift-add multiply (or single-cycle when FAST_MUL=1) and restoring
// divide on operand magnitudes. A FIX cycle then applies sign correction and
// writes HI/LO. A busy/done handshake and a flush cancel are provided.
module mult_div_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned FAST_MUL = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned DW = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_a_q, neg_a_d;     // negate product / quotient
    logic             neg_r_q, neg_r_d;     // negate remainder
    logic [WIDTH-1:0] rs_q, rs_d;           // raw dividend for divide-by-zero
    logic [WIDTH-1:0] opb_q, opb_d;         // multiplicand or divisor magnitude
    logic [WIDTH-1:0] wh_q, wh_d;           // partial product high / remainder
    logic [WIDTH-1:0] wl_q, wl_d;           // multiplier shift / quotient
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic             op_valid, accept, op_signed, rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic [DW-1:0]    fast_mag, fast_prod, fix_prod;
    logic [WIDTH:0]   mul_sum, div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem, quot, rem;

    // Operand decode, magnitudes and per-iteration datapath
    assign op_valid  = (op <= OP_MTLO);
    assign accept    = start && (state_q == S_IDLE) && op_valid && !cancel;
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign rs_neg    = op_signed && rs_data[WIDTH-1];
    assign rt_neg    = op_signed && rt_data[WIDTH-1];
    assign rs_mag    = rs_neg ? (~rs_data + WIDTH'(1)) : rs_data;
    assign rt_mag    = rt_neg ? (~rt_data + WIDTH'(1)) : rt_data;

    assign fast_mag  = DW'(rs_mag) * DW'(rt_mag);
    assign fast_prod = (rs_neg ^ rt_neg) ? (~fast_mag + DW'(1)) : fast_mag;

    assign mul_sum   = {1'b0, wh_q} + (wl_q[0] ? {1'b0, opb_q} : {(WIDTH + 1){1'b0}});
    assign div_trial = {wh_q, wl_q[WIDTH-1]};
    assign div_ge    = (div_trial >= {1'b0, opb_q});
    assign div_rem   = div_trial[WIDTH-1:0] - opb_q;

    assign fix_prod  = neg_a_q ? (~{wh_q, wl_q} + DW'(1)) : {wh_q, wl_q};
    assign quot      = neg_a_q ? (~wl_q + WIDTH'(1)) : wl_q;
    assign rem       = neg_r_q ? (~wh_q + WIDTH'(1)) : wh_q;

    // Next-state, iteration and HI/LO write logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_a_d    = neg_a_q;
        neg_r_d    = neg_r_q;
        rs_d       = rs_q;
        opb_d      = opb_q;
        wh_d       = wh_q;
        wl_d       = wl_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    div_zero_d = 1'b0;
                    case (op)
                        OP_MTHI: begin
                            hi_d   = rs_data;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = rs_data;
                            done_d = 1'b1;
                        end
                        OP_MULT, OP_MULTU: begin
                            if (FAST_MUL != 0) begin
                                {hi_d, lo_d} = fast_prod;
                                done_d       = 1'b1;
                            end else begin
                                state_d  = S_RUN;
                                cnt_d    = '0;
                                is_div_d = 1'b0;
                                neg_a_d  = rs_neg ^ rt_neg;
                                opb_d    = rs_mag;
                                wh_d     = '0;
                                wl_d     = rt_mag;
                            end
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d    = S_RUN;
                            cnt_d      = '0;
                            is_div_d   = 1'b1;
                            neg_a_d    = rs_neg ^ rt_neg;
                            neg_r_d    = rs_neg;
                            rs_d       = rs_data;
                            opb_d      = rt_mag;
                            wh_d       = '0;
                            wl_d       = rs_mag;
                            div_zero_d = (rt_data == '0);
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (is_div_q) begin
                        wh_d = div_ge ? div_rem : div_trial[WIDTH-1:0];
                        wl_d = {wl_q[WIDTH-2:0], div_ge};
                    end else begin
                        wh_d = mul_sum[WIDTH:1];
                        wl_d = {mul_sum[0], wl_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        if (div_zero_q) begin
                            lo_d = '1;
                            hi_d = rs_q;
                        end else begin
                            lo_d = quot;
                            hi_d = rem;
                        end
                    end else begin
                        {hi_d, lo_d} = fix_prod;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_a_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            rs_q       <= '0;
            opb_q      <= '0;
            wh_q       <= '0;
            wl_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_a_q    <= neg_a_d;
            neg_r_q    <= neg_r_d;
            rs_q       <= rs_d;
            opb_q      <= opb_d;
            wh_q       <= wh_d;
            wl_q       <= wl_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: one iterative instance and
// one FAST_MUL instance sharing operand inputs, each with its own start.
module tb_mult_div_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        cancel;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        use_fast;

    logic        s_start, s_busy, s_done, s_dz;
    logic [31:0] s_hi, s_lo;
    logic        f_start, f_busy, f_done, f_dz;
    logic [31:0] f_hi, f_lo;

    logic        cur_busy, cur_done, cur_dz;
    logic [31:0] cur_hi, cur_lo;

    int n_checks = 0;
    int n_errors = 0;
    int dcnt;

    always #5 clock = ~clock;

    assign s_start  = start && !use_fast;
    assign f_start  = start && use_fast;
    assign cur_busy = use_fast ? f_busy : s_busy;
    assign cur_done = use_fast ? f_done : s_done;
    assign cur_dz   = use_fast ? f_dz   : s_dz;
    assign cur_hi   = use_fast ? f_hi   : s_hi;
    assign cur_lo   = use_fast ? f_lo   : s_lo;

    mult_div_unit #(.WIDTH(32), .FAST_MUL(0)) u_dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (s_start),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .cancel   (cancel),
        .busy     (s_busy),
        .done     (s_done),
        .div_zero (s_dz),
        .hi       (s_hi),
        .lo       (s_lo)
    );

    mult_div_unit #(.WIDTH(32), .FAST_MUL(1)) u_dut_fast (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (f_start),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .cancel   (1'b0),
        .busy     (f_busy),
        .done     (f_done),
        .div_zero (f_dz),
        .hi       (f_hi),
        .lo       (f_lo)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one op, then count busy cycles until done (bounded) and check timing
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int exp_cyc, input int exp_busy, input string tag);
        int cyc;
        int bcnt;
        op      = o;
        rs_data = a;
        rt_data = b;
        start   = 1'b1;
        step();
        start   = 1'b0;
        rs_data = 32'hDEAD_BEEF;
        rt_data = 32'h0;
        cyc  = 1;
        bcnt = 0;
        while (!cur_done && cyc < 100) begin
            if (cur_busy) bcnt++;
            step();
            cyc++;
        end
        check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_busy));
        check({tag, "_busy_at_done"}, 64'(cur_busy), 64'(0));
        step();
        check({tag, "_done_one_cycle"}, 64'(cur_done), 64'(0));
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        cancel   = 1'b0;
        op       = 3'b000;
        rs_data  = 32'h0;
        rt_data  = 32'h0;
        use_fast = 1'b0;
        step();
        step();
        check("rst_busy", 64'(s_busy), 64'(0));
        check("rst_done", 64'(s_done), 64'(0));
        check("rst_dz",   64'(s_dz),   64'(0));
        check("rst_hi",   64'(s_hi),   64'(0));
        check("rst_lo",   64'(s_lo),   64'(0));
        check("rst_fast_hilo", {f_hi, f_lo}, 64'(0));
        #3;
        reset_n = 1'b1;
        step();

        // Unsigned multiply of max values
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 33, "multu");
        check("multu_hi", 64'(s_hi), 64'h0000_0000_FFFF_FFFE);
        check("multu_lo", 64'(s_lo), 64'h0000_0000_0000_0001);

        // Signed multiply, iterative and single-cycle
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 34, 33, "mult");
        check("mult_hi", 64'(s_hi), 64'h0000_0000_FFFF_FFFF);
        check("mult_lo", 64'(s_lo), 64'h0000_0000_FFFF_FFF1);
        use_fast = 1'b1;
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1, 0, "mult_fast");
        check("mult_fast_hi", 64'(f_hi), 64'h0000_0000_FFFF_FFFF);
        check("mult_fast_lo", 64'(f_lo), 64'h0000_0000_FFFF_FFF1);
        use_fast = 1'b0;

        // Signed divide truncating toward zero
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 34, 33, "div");
        check("div_lo", 64'(s_lo), 64'h0000_0000_FFFF_FFFD);
        check("div_hi", 64'(s_hi), 64'h0000_0000_FFFF_FFFF);
        check("div_dz", 64'(s_dz), 64'(0));

        // Divide by zero, then MTLO clears the flag
        run_op(OP_DIVU, 32'd7, 32'd0, 34, 33, "divz");
        check("divz_lo", 64'(s_lo), 64'h0000_0000_FFFF_FFFF);
        check("divz_hi", 64'(s_hi), 64'h0000_0000_0000_0007);
        check("divz_dz", 64'(s_dz), 64'(1));
        run_op(OP_MTLO, 32'h0000_0055, 32'd0, 1, 0, "mtlo");
        check("mtlo_lo", 64'(s_lo), 64'h0000_0000_0000_0055);
        check("mtlo_hi", 64'(s_hi), 64'h0000_0000_0000_0007);
        check("mtlo_dz", 64'(s_dz), 64'(0));

        // Most-negative / -1 overflow case
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 33, "divovf");
        check("divovf_lo", 64'(s_lo), 64'h0000_0000_8000_0000);
        check("divovf_hi", 64'(s_hi), 64'h0000_0000_0000_0000);
        check("divovf_dz", 64'(s_dz), 64'(0));

        // MTHI, then cancel a DIVU after an ignored mid-run start
        run_op(OP_MTHI, 32'h0000_1234, 32'd0, 1, 0, "mthi");
        check("mthi_hi", 64'(s_hi), 64'h0000_0000_0000_1234);
        op      = OP_DIVU;
        rs_data = 32'd100;
        rt_data = 32'd7;
        start   = 1'b1;
        step();
        start   = 1'b0;
        repeat (4) step();
        op      = OP_MULT;
        rs_data = 32'd2;
        rt_data = 32'd3;
        start   = 1'b1;
        step();
        start   = 1'b0;
        check("ign_busy", 64'(s_busy), 64'(1));
        check("ign_done", 64'(s_done), 64'(0));
        repeat (4) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("cancel_busy", 64'(s_busy), 64'(0));
        check("cancel_done", 64'(s_done), 64'(0));
        check("cancel_hi",   64'(s_hi),   64'h0000_0000_0000_1234);
        check("cancel_lo",   64'(s_lo),   64'h0000_0000_8000_0000);
        check("cancel_dz",   64'(s_dz),   64'(0));
        dcnt = 0;
        repeat (40) begin
            step();
            if (s_done) dcnt++;
        end
        check("cancel_no_done", 64'(dcnt), 64'(0));
        check("cancel_hi_late", 64'(s_hi), 64'h0000_0000_0000_1234);

        // Reserved opcode is ignored
        op      = 3'b110;
        rs_data = 32'h0000_FFFF;
        start   = 1'b1;
        step();
        start   = 1'b0;
        check("rsvd_done", 64'(s_done), 64'(0));
        check("rsvd_busy", 64'(s_busy), 64'(0));
        check("rsvd_hilo", {s_hi, s_lo}, 64'h0000_1234_8000_0000);

        // Start together with cancel in IDLE is ignored
        op      = OP_MTHI;
        rs_data = 32'h0000_AAAA;
        start   = 1'b1;
        cancel  = 1'b1;
        step();
        start   = 1'b0;
        cancel  = 1'b0;
        check("startcancel_done", 64'(s_done), 64'(0));
        check("startcancel_hi",   64'(s_hi),   64'h0000_0000_0000_1234);

        // Asynchronous reset in the middle of a DIV
        op      = OP_DIV;
        rs_data = 32'd100;
        rt_data = 32'd7;
        start   = 1'b1;
        step();
        start   = 1'b0;
        repeat (5) step();
        check("prereset_busy", 64'(s_busy), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_busy", 64'(s_busy), 64'(0));
        check("areset_hilo", {s_hi, s_lo}, 64'(0));
        check("areset_dz",   64'(s_dz),   64'(0));
        #3;
        reset_n = 1'b1;
        step();
        run_op(OP_DIVU, 32'd100, 32'd7, 34, 33, "divu");
        check("divu_lo", 64'(s_lo), 64'd14);
        check("divu_hi", 64'(s_hi), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
